// File: rtl/shift_link_rx.sv
// Serial word receiver: collects WIDTH LSB-first data bits plus an odd-parity bit
// framed by a start marker, and presents each word through a one-entry output buffer.
module shift_link_rx #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sdata,
    input  logic             svalid,
    input  logic             sframe,
    input  logic             dready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] data,
    output logic             dvalid,
    output logic             perr,
    output logic             overrun,
    output logic             ferr
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic             done;
    logic             frame_err;
    logic             accept;
    logic             drop;

    // Odd parity: data plus parity bit must hold an odd number of ones.
    function automatic logic odd_par_err(input logic [WIDTH-1:0] w, input logic p);
        return ~(^w ^ p);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            shreg <= shreg_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        shreg_nx  = shreg;
        done      = 1'b0;
        frame_err = 1'b0;
        if (svalid) begin
            if (sframe) begin
                // A marker always restarts; mid-word it is a framing error.
                frame_err = (state != IDLE);
                shreg_nx  = {sdata, {(WIDTH-1){1'b0}}};
                cnt_nx    = CW'(1);
                state_nx  = SHIFT;
            end else begin
                case (state)
                    SHIFT: begin
                        shreg_nx = {sdata, shreg[WIDTH-1:1]};
                        cnt_nx   = cnt + CW'(1);
                        if (cnt == LAST) state_nx = PARITY;
                    end
                    PARITY: begin
                        done     = 1'b1;
                        cnt_nx   = '0;
                        state_nx = IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign accept = done && (!dvalid || dready);
    assign drop   = done && dvalid && !dready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data    <= '0;
            dvalid  <= 1'b0;
            perr    <= 1'b0;
            overrun <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            if (accept) begin
                data   <= shreg;
                dvalid <= 1'b1;
                perr   <= odd_par_err(shreg, sdata);
            end else if (dvalid && dready) begin
                dvalid <= 1'b0;
            end
            // Sticky flags: a set on the same edge as a clear wins.
            if (drop)         overrun <= 1'b1;
            else if (clr_err) overrun <= 1'b0;
            if (frame_err)    ferr <= 1'b1;
            else if (clr_err) ferr <= 1'b0;
        end
    end

endmodule

// File: doc/shift_link_rx.md
SHIFT_LINK_RX -- requirements
Module: shift_link_rx

Interface
REQ-001 Parameter WIDTH, default 16, data bits per serial word (range 2..32).
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 RESET  input  1  reset, asynchronous, active-high.
REQ-004 SDATA  input  1  serial bit from the upstream shift-register transmitter.
REQ-005 SVALID  input  1  bit strobe; SDATA is sampled only on edges where SVALID=1.
REQ-006 SFRAME  input  1  start-of-word marker; qualified by SVALID; marks the first data bit.
REQ-007 DATA  output  WIDTH  received word, LSB = first bit received.
REQ-008 DVALID  output  1  DATA holds an unconsumed word.
REQ-009 DREADY  input  1  consumer accepts DATA on an edge where DVALID=1 and DREADY=1.
REQ-010 PERR  output  1  parity error flag for the word currently in DATA.
REQ-011 OVERRUN  output  1  sticky: a completed word was dropped.
REQ-012 FERR  output  1  sticky: SFRAME arrived mid-word.
REQ-013 CLR_ERR  input  1  synchronous clear of OVERRUN and FERR.

Function
REQ-014 Frame format: WIDTH data bits, LSB first, then one odd-parity bit (data plus parity has an odd count of ones); SFRAME=1 only with the first data bit.
REQ-015 States: IDLE, SHIFT, PARITY; the output buffer is a separate one-entry register with DVALID.
REQ-016 IDLE: a qualified bit (SVALID=1) with SFRAME=1 loads the bit into shift-register bit WIDTH-1, sets the bit counter to 1 and enters SHIFT; qualified bits with SFRAME=0 are ignored.
REQ-017 SHIFT: each qualified bit shifts the register right with SDATA entering bit WIDTH-1 and increments the counter; the counter reaching WIDTH enters PARITY.
REQ-018 PARITY: the next qualified bit is the parity bit; the word completes on that edge and the state returns to IDLE.
REQ-019 On completion with DVALID=0, or with DVALID=1 and DREADY=1 on the same edge: DATA is loaded with the shifted word, DVALID=1, and PERR = the result of the odd-parity check.
REQ-020 On completion with DVALID=1 and DREADY=0: the new word is dropped, OVERRUN is set, and DATA, PERR and DVALID are unchanged.
REQ-021 A handshake (DVALID=1, DREADY=1) with no completion on the same edge clears DVALID; DATA is held.
REQ-022 A qualified bit with SFRAME=1 while in SHIFT or PARITY sets FERR, discards the partial word and restarts as in REQ-016 using that bit.
REQ-023 Edges with SVALID=0 change no receive state; there is no timeout, and gaps of any length between bits are legal.
REQ-024 CLR_ERR=1 clears OVERRUN and FERR; if a set condition occurs on the same edge, the flag is set (set wins).
REQ-025 Latency: DVALID rises on the edge that samples the parity bit; the word is visible on the following cycle.
REQ-026 DATA changes only on a load edge (REQ-019).

Reset
REQ-027 RESET=1 forces, immediately and without a clock edge: state IDLE, bit counter 0, shift register 0, DATA=0, DVALID=0, PERR=0, OVERRUN=0, FERR=0.
REQ-028 A RESET asserted mid-word discards the partial word; after release, reception resumes only at the next SFRAME.

Verification
REQ-029 WIDTH=16, DREADY=1: send 0xA5C3 LSB first with parity=1 (eight ones, so odd parity requires 1) -> DVALID pulses for one cycle, DATA=0xA5C3, PERR=0.
REQ-030 Same word with parity=0 -> DATA=0xA5C3, PERR=1, OVERRUN=0.
REQ-031 DREADY=0: send 0x0001 (parity 0) then 0xFFFF (parity 1) -> DATA stays 0x0001, OVERRUN=1; pulse CLR_ERR -> OVERRUN=0.
REQ-032 Assert SFRAME at bit 7 of a word, then send a full 0x1234 (parity 0) -> FERR=1, DATA=0x1234, PERR=0.
REQ-033 Insert random SVALID=0 gaps of 0..5 cycles between the bits of 0x8001 -> result identical to the gap-free case.
REQ-034 Assert RESET at bit 9 of a word while DVALID=1 -> all outputs 0 at once; a word sent after release is received correctly.
